// File: rtl/appr_error_stats.sv
// Error statistics for an approximate multiplier: accumulates the signed error,
// squared error (saturating) and |exact| over a run of N_SAMPLES accepted pairs.
module appr_error_stats #(
    parameter int DATA_W    = 32,
    parameter int N_SAMPLES = 1024,
    parameter int ACC_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] appr,
    input  logic [DATA_W-1:0] exact,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sample_cnt,
    output logic [ACC_W-1:0]  err_sum,
    output logic [ACC_W-1:0]  err_sq_sum,
    output logic [ACC_W-1:0]  abs_sum,
    output logic              sq_sat
);

    localparam int EW  = DATA_W + 1;
    localparam int SQW = 2 * DATA_W + 2;
    localparam int SW  = ((ACC_W > SQW) ? ACC_W : SQW) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t state, state_nxt;
    logic   clear;
    logic   accept;
    logic   last_accept;

    logic                  v1, v2;
    logic signed [EW-1:0]  err1, err2;
    logic [EW-1:0]         abs1, abs2;
    logic [SQW-1:0]        sq2;

    logic [EW-1:0]         exact_ext;
    logic [EW-1:0]         exact_abs;
    logic signed [SQW-1:0] prod;
    logic [SW-1:0]         sq_sum_ext;

    assign in_ready    = (state == ACCUM) && (sample_cnt < 16'(N_SAMPLES));
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_cnt == 16'(N_SAMPLES - 1));
    assign busy        = (state == ACCUM) || (state == DRAIN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN waits for stage 1 to empty; the last sample then leaves stage 2
    // on the same edge that enters DONE, so done and the final sums align.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                    clear     = 1'b1;
                end
            end
            ACCUM: begin
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = ACCUM;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign exact_ext  = {exact[DATA_W-1], exact};
    assign exact_abs  = exact[DATA_W-1] ? (~exact_ext + EW'(1)) : exact_ext;
    assign prod       = SQW'(err1) * SQW'(err1);
    assign sq_sum_ext = SW'(err_sq_sum) + SW'(sq2);

    // Stage 1 forms the exact error, stage 2 registers its square, and the
    // accumulators fold stage 2 in, giving the two-edge result latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            err1       <= '0;
            abs1       <= '0;
            err2       <= '0;
            abs2       <= '0;
            sq2        <= '0;
            sample_cnt <= '0;
            err_sum    <= '0;
            err_sq_sum <= '0;
            abs_sum    <= '0;
            sq_sat     <= 1'b0;
        end else if (clear) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            sample_cnt <= '0;
            err_sum    <= '0;
            err_sq_sum <= '0;
            abs_sum    <= '0;
            sq_sat     <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                err1       <= {appr[DATA_W-1], appr} - exact_ext;
                abs1       <= exact_abs;
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (v1) begin
                err2 <= err1;
                abs2 <= abs1;
                sq2  <= prod;
            end
            if (v2) begin
                err_sum <= err_sum + ACC_W'(err2);
                abs_sum <= abs_sum + ACC_W'(abs2);
                if (|sq_sum_ext[SW-1:ACC_W]) begin
                    err_sq_sum <= '1;
                    sq_sat     <= 1'b1;
                end else begin
                    err_sq_sum <= sq_sum_ext[ACC_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_appr_error_stats.sv
// Self-checking bench for appr_error_stats: directed corner runs on several
// parameterisations plus randomized runs against an arithmetic reference model.
`timescale 1ns/1ps
module tb_appr_error_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  st;
    logic        in_valid;
    logic [31:0] appr, exact;

    logic        rdy[4], bsy[4], dn[4], sat[4];
    logic [15:0] cnt[4];
    logic [63:0] es[3], esq[3], as_[3];
    logic [7:0]  es8, esq8, as8;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] ma[$];
    logic [31:0] me[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        appr_error_stats #(
            .DATA_W(32),
            .N_SAMPLES(g == 0 ? 4 : (g == 1 ? 1 : 3)),
            .ACC_W(64)
        ) u_dut (
            .clk(clk), .rst(rst), .start(st[g]), .in_valid(in_valid),
            .in_ready(rdy[g]), .appr(appr), .exact(exact), .busy(bsy[g]),
            .done(dn[g]), .sample_cnt(cnt[g]), .err_sum(es[g]),
            .err_sq_sum(esq[g]), .abs_sum(as_[g]), .sq_sat(sat[g])
        );
    end

    appr_error_stats #(.DATA_W(32), .N_SAMPLES(2), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st[3]), .in_valid(in_valid),
        .in_ready(rdy[3]), .appr(appr), .exact(exact), .busy(bsy[3]),
        .done(dn[3]), .sample_cnt(cnt[3]), .err_sum(es8),
        .err_sq_sum(esq8), .abs_sum(as8), .sq_sat(sat[3])
    );

    // Callers are positioned just after a rising edge.
    task automatic do_start(input int id);
        st[id] = 1'b1;
        @(posedge clk); #1;
        st[id] = 1'b0;
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] e, input int gaps);
        bit got;
        got = 1'b0;
        in_valid = 1'b0;
        repeat (gaps) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        appr = a;
        exact = e;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rdy[id]) got = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL accept_timeout id=%0d: got no accept, want accept", id);
        end
    endtask

    // Reference: sums over the recorded pairs in wide plain arithmetic.
    task automatic model(output longint esum, output logic [63:0] esqv,
                         output logic esat, output logic [63:0] eabs);
        logic [127:0] acc;
        acc  = '0;
        esum = 0;
        eabs = '0;
        foreach (ma[i]) begin
            longint d, m, x;
            d = longint'($signed(ma[i])) - longint'($signed(me[i]));
            m = (d < 0) ? -d : d;
            x = longint'($signed(me[i]));
            acc  = acc + 128'(m) * 128'(m);
            esum = esum + d;
            eabs = eabs + 64'((x < 0) ? -x : x);
        end
        esat = (acc > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        esqv = esat ? 64'hFFFF_FFFF_FFFF_FFFF : acc[63:0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (cnt[0] !== 16'd0) begin mismatched++; $display("[TB] FAIL rst_cnt: got %0d want 0", cnt[0]); end
        compared++; if (es[0] !== 64'd0 || esq[0] !== 64'd0 || as_[0] !== 64'd0) begin mismatched++; $display("[TB] FAIL rst_sums: got %0h/%0h/%0h want 0/0/0", es[0], esq[0], as_[0]); end
        compared++; if ({rdy[0], bsy[0], dn[0], sat[0]} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_flags: got %b want 0000", {rdy[0], bsy[0], dn[0], sat[0]}); end
        rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        appr = 32'd7;
        exact = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        compared++; if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0 || cnt[0] !== 16'd0 || es[0] !== 64'd0) begin mismatched++; $display("[TB] FAIL idle_no_start: got rdy=%b busy=%b cnt=%0d err=%0d want 0 0 0 0", rdy[0], bsy[0], cnt[0], es[0]); end
    endtask

    task automatic test_directed4();
        do_start(0);
        compared++; if (bsy[0] !== 1'b1 || cnt[0] !== 16'd0) begin mismatched++; $display("[TB] FAIL d4_started: got busy=%b cnt=%0d want 1 0", bsy[0], cnt[0]); end
        send(0, 32'd10, 32'd10, 0);
        send(0, 32'd12, 32'd10, 0);
        send(0, -32'sd3, 32'd0, 0);
        send(0, 32'd5, 32'd8, 0);
        @(negedge clk);
        compared++; if (rdy[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL d4_ready_after_last: got %b want 0", rdy[0]); end
        @(negedge clk);
        compared++; if (dn[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL d4_done_early: got %b want 0", dn[0]); end
        @(negedge clk);
        compared++; if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL d4_done: got done=%b busy=%b want 1 0", dn[0], bsy[0]); end
        compared++; if (es[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin mismatched++; $display("[TB] FAIL d4_err_sum: got %0d want -4", $signed(es[0])); end
        compared++; if (esq[0] !== 64'd22) begin mismatched++; $display("[TB] FAIL d4_err_sq_sum: got %0d want 22", esq[0]); end
        compared++; if (as_[0] !== 64'd28) begin mismatched++; $display("[TB] FAIL d4_abs_sum: got %0d want 28", as_[0]); end
        compared++; if (cnt[0] !== 16'd4 || sat[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL d4_cnt_sat: got cnt=%0d sat=%b want 4 0", cnt[0], sat[0]); end
        repeat (3) @(negedge clk);
        compared++; if (dn[0] !== 1'b1 || es[0] !== 64'hFFFF_FFFF_FFFF_FFFC || esq[0] !== 64'd22 || cnt[0] !== 16'd4) begin mismatched++; $display("[TB] FAIL d4_hold: got done=%b err=%0d sq=%0d cnt=%0d want 1 -4 22 4", dn[0], $signed(es[0]), esq[0], cnt[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_min_operand();
        do_start(1);
        send(1, 32'h8000_0000, 32'h8000_0000, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        compared++; if (dn[1] !== 1'b1) begin mismatched++; $display("[TB] FAIL min_done: got %b want 1", dn[1]); end
        compared++; if (es[1] !== 64'd0 || esq[1] !== 64'd0) begin mismatched++; $display("[TB] FAIL min_err: got %0d/%0d want 0/0", es[1], esq[1]); end
        compared++; if (as_[1] !== 64'h0000_0000_8000_0000) begin mismatched++; $display("[TB] FAIL min_abs_sum: got %0h want 80000000", as_[1]); end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        do_start(2);
        send(2, 32'd1, 32'd0, 2);
        send(2, 32'd0, 32'd1, 2);
        send(2, 32'd2, 32'd2, 2);
        @(negedge clk);
        compared++; if (rdy[2] !== 1'b0) begin mismatched++; $display("[TB] FAIL bub_ready_after_last: got %b want 0", rdy[2]); end
        @(negedge clk);
        @(negedge clk);
        compared++; if (dn[2] !== 1'b1 || cnt[2] !== 16'd3) begin mismatched++; $display("[TB] FAIL bub_done: got done=%b cnt=%0d want 1 3", dn[2], cnt[2]); end
        compared++; if (es[2] !== 64'd0 || esq[2] !== 64'd2 || as_[2] !== 64'd3) begin mismatched++; $display("[TB] FAIL bub_sums: got %0d/%0d/%0d want 0/2/3", es[2], esq[2], as_[2]); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        do_start(3);
        send(3, 32'd15, 32'd0, 0);
        send(3, 32'd10, 32'd0, 0);
        repeat (3) @(negedge clk);
        compared++; if (dn[3] !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_done: got %b want 1", dn[3]); end
        compared++; if (esq8 !== 8'd255 || sat[3] !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_clamp: got sq=%0d sat=%b want 255 1", esq8, sat[3]); end
        compared++; if (es8 !== 8'd25 || as8 !== 8'd0) begin mismatched++; $display("[TB] FAIL sat_other_sums: got %0d/%0d want 25/0", es8, as8); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        longint xs; logic [63:0] xq, xa; logic xsat;
        do_start(0);
        st[0] = 1'b1;
        ma.delete(); me.delete();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a, e;
            a = 32'($urandom_range(0, 400)) - 32'd200;
            e = 32'($urandom_range(0, 400)) - 32'd200;
            send(0, a, e, i);
            ma.push_back(a); me.push_back(e);
        end
        compared++; if (cnt[0] !== 16'd3 || bsy[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_start_cnt: got cnt=%0d busy=%b want 3 1", cnt[0], bsy[0]); end
        st[0] = 1'b0;
        send(0, 32'd100, 32'hFFFF_FF00, 0);
        ma.push_back(32'd100); me.push_back(32'hFFFF_FF00);
        repeat (3) @(negedge clk);
        model(xs, xq, xsat, xa);
        compared++; if (dn[0] !== 1'b1 || es[0] !== 64'(xs) || esq[0] !== xq || as_[0] !== xa) begin mismatched++; $display("[TB] FAIL hold_start_sums: got done=%b %0d/%0d/%0d want 1 %0d/%0d/%0d", dn[0], $signed(es[0]), esq[0], as_[0], xs, xq, xa); end
        @(posedge clk); #1;
        do_start(0);
        compared++; if (cnt[0] !== 16'd0 || es[0] !== 64'd0 || esq[0] !== 64'd0 || as_[0] !== 64'd0 || dn[0] !== 1'b0 || bsy[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_clear: got cnt=%0d %0h/%0h/%0h done=%b busy=%b want 0 0/0/0 0 1", cnt[0], es[0], esq[0], as_[0], dn[0], bsy[0]); end
        ma.delete(); me.delete();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, e;
            a = $urandom; e = $urandom;
            send(0, a, e, 0);
            ma.push_back(a); me.push_back(e);
        end
        repeat (3) @(negedge clk);
        model(xs, xq, xsat, xa);
        compared++; if (dn[0] !== 1'b1 || es[0] !== 64'(xs) || as_[0] !== xa) begin mismatched++; $display("[TB] FAIL restart_run: got done=%b %0d/%0d want 1 %0d/%0d", dn[0], $signed(es[0]), as_[0], xs, xa); end
        @(posedge clk); #1;
    endtask

    task automatic test_midrun_reset();
        longint xs; logic [63:0] xq, xa; logic xsat;
        do_start(0);
        send(0, 32'd1000, 32'd3, 0);
        send(0, 32'hFFFF_0000, 32'd77, 0);
        rst = 1'b1;
        #2;
        compared++; if (cnt[0] !== 16'd0 || es[0] !== 64'd0 || esq[0] !== 64'd0 || as_[0] !== 64'd0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0 || dn[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_async: got cnt=%0d %0h/%0h/%0h busy=%b rdy=%b done=%b want all 0", cnt[0], es[0], esq[0], as_[0], bsy[0], rdy[0], dn[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (es[0] !== 64'd0 || as_[0] !== 64'd0 || bsy[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_flush: got %0h/%0h busy=%b want 0/0 0", es[0], as_[0], bsy[0]); end
        do_start(0);
        ma.delete(); me.delete();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, e;
            a = 32'($urandom_range(0, 60000)) - 32'd30000;
            e = 32'($urandom_range(0, 60000)) - 32'd30000;
            send(0, a, e, 0);
            ma.push_back(a); me.push_back(e);
        end
        repeat (3) @(negedge clk);
        model(xs, xq, xsat, xa);
        compared++; if (dn[0] !== 1'b1 || es[0] !== 64'(xs) || esq[0] !== xq || as_[0] !== xa || cnt[0] !== 16'd4) begin mismatched++; $display("[TB] FAIL midrst_run: got done=%b %0d/%0d/%0d cnt=%0d want 1 %0d/%0d/%0d 4", dn[0], $signed(es[0]), esq[0], as_[0], cnt[0], xs, xq, xa); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        longint xs; logic [63:0] xq, xa; logic xsat;
        for (int run = 0; run < 10; run++) begin
            do_start(0);
            ma.delete(); me.delete();
            for (int i = 0; i < 4; i++) begin
                logic [31:0] a, e;
                if (run % 2 == 1) begin
                    a = $urandom; e = $urandom;
                end else begin
                    a = 32'($urandom_range(0, 2000)) - 32'd1000;
                    e = 32'($urandom_range(0, 2000)) - 32'd1000;
                end
                send(0, a, e, $urandom_range(0, 2));
                ma.push_back(a); me.push_back(e);
            end
            @(negedge clk);
            @(negedge clk);
            compared++; if (dn[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL rnd%0d_done_early: got %b want 0", run, dn[0]); end
            @(negedge clk);
            model(xs, xq, xsat, xa);
            compared++; if (dn[0] !== 1'b1 || cnt[0] !== 16'd4) begin mismatched++; $display("[TB] FAIL rnd%0d_done: got done=%b cnt=%0d want 1 4", run, dn[0], cnt[0]); end
            compared++; if (es[0] !== 64'(xs)) begin mismatched++; $display("[TB] FAIL rnd%0d_err_sum: got %0d want %0d", run, $signed(es[0]), xs); end
            compared++; if (esq[0] !== xq || sat[0] !== xsat) begin mismatched++; $display("[TB] FAIL rnd%0d_err_sq: got %0h sat=%b want %0h sat=%b", run, esq[0], sat[0], xq, xsat); end
            compared++; if (as_[0] !== xa) begin mismatched++; $display("[TB] FAIL rnd%0d_abs_sum: got %0h want %0h", run, as_[0], xa); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        st       = 4'b0000;
        in_valid = 1'b0;
        appr     = '0;
        exact    = '0;
        rst      = 1'b1;
        test_reset();
        test_directed4();
        test_min_operand();
        test_bubbles();
        test_saturation();
        test_start_ignored();
        test_midrun_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
